nn_search_ctrl: RTL and testbench

Sequencer that runs one nearest-neighbour search over a vertex table using the shared iterative `distance` unit. On start it latches a query point, then reads vertices 0..N-1 from a synchronous vertex BRAM one at a time. Each vertex is issued to the distance unit, the squared-distance result is awaited, and the running minimum and its index are tracked. It sits between the top-level query FSM and the vertex memory / distance datapath.

---
 rtl/nn_pkg.sv | 7 +
 rtl/nn_search_ctrl_min_tracker.sv | 29 ++
 rtl/nn_search_ctrl.sv | 115 +++++++++++
 tb/tb_nn_search_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared types and constants for the nearest-neighbour search block.
package nn_pkg;
    localparam int DIM = 2;
    localparam logic [31:0] DIST_MAX = 32'hFFFF_FFFF;
    typedef logic [DIM-1:0][31:0] point_t;
    typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, FINISH} nn_state_t;
endpackage

// File: rtl/nn_search_ctrl_min_tracker.sv
// min_tracker: running minimum distance and its index, with clear and update strobe.
module min_tracker
    import nn_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clr,
    input  logic             upd,
    input  logic [31:0]      cand_dist,
    input  logic [IDX_W-1:0] cand_idx,
    output logic [31:0]      best_dist,
    output logic [IDX_W-1:0] best_idx
);
    // strict compare keeps the earlier index on ties
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            best_dist <= DIST_MAX;
            best_idx  <= '0;
        end else if (clr) begin
            best_dist <= DIST_MAX;
            best_idx  <= '0;
        end else if (upd && cand_dist < best_dist) begin
            best_dist <= cand_dist;
            best_idx  <= cand_idx;
        end
    end
endmodule

// File: rtl/nn_search_ctrl.sv
// nn_search_ctrl: sequences one nearest-neighbour search over the vertex BRAM
// through the iterative distance unit, one vertex in flight at a time.
module nn_search_ctrl
    import nn_pkg::*;
#(
    parameter int DIM          = nn_pkg::DIM,
    parameter int MAX_VERTICES = 64,
    parameter int ADDR_W       = $clog2(MAX_VERTICES),
    parameter int RD_LAT       = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic [DIM-1:0][31:0]    query_pos_in,
    input  logic [ADDR_W:0]         num_vertices_in,
    output logic [ADDR_W-1:0]       vertex_addr_out,
    input  logic [DIM-1:0][31:0]    vertex_pos_in,
    output logic [DIM-1:0]          dist_valid_out,
    output logic [DIM-1:0][31:0]    dist_vertex_out,
    output logic [DIM-1:0][31:0]    dist_query_out,
    input  logic [31:0]             dist_sq_in,
    input  logic                    dist_valid_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    found_out,
    output logic                    timeout_out,
    output logic [ADDR_W-1:0]       best_idx_out,
    output logic [31:0]             best_dist_sq_out
);
    localparam int RD_W = $clog2(RD_LAT + 1);
    localparam int IS_W = $clog2(DIM + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] N_MAX = (ADDR_W + 1)'(MAX_VERTICES);

    nn_state_t         state, state_nx;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   n_lat;
    logic [RD_W-1:0]   rd_cnt;
    logic [IS_W-1:0]   issue_cnt;
    logic [TO_W-1:0]   wait_cnt;
    logic              accept, rd_done, issue_done, last, expired;

    assign accept     = state == IDLE && start_in;
    assign rd_done    = rd_cnt == RD_W'(RD_LAT);
    assign issue_done = issue_cnt == IS_W'(DIM - 1);
    assign last       = {1'b0, idx} == n_lat - 1'b1;
    assign expired    = wait_cnt == TO_W'(TIMEOUT - 1);
    assign vertex_addr_out = idx;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !start_in ? IDLE : (num_vertices_in == '0 ? FINISH : READ);
            READ:    state_nx = rd_done ? ISSUE : READ;
            ISSUE:   state_nx = issue_done ? WAIT : ISSUE;
            WAIT:    state_nx = dist_valid_in ? (last ? FINISH : READ) : (expired ? FINISH : WAIT);
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_out       = state != IDLE;
        done_out       = state == FINISH;
        dist_valid_out = {DIM{state == ISSUE}};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx             <= '0;
            n_lat           <= '0;
            rd_cnt          <= '0;
            issue_cnt       <= '0;
            wait_cnt        <= '0;
            dist_query_out  <= '0;
            dist_vertex_out <= '0;
            found_out       <= 1'b0;
            timeout_out     <= 1'b0;
        end else begin
            rd_cnt    <= state == READ  ? rd_cnt + 1'b1    : '0;
            issue_cnt <= state == ISSUE ? issue_cnt + 1'b1 : '0;
            wait_cnt  <= state == WAIT  ? wait_cnt + 1'b1  : '0;
            if (accept) begin
                dist_query_out <= query_pos_in;
                n_lat          <= num_vertices_in > N_MAX ? N_MAX : num_vertices_in;
                idx            <= '0;
                found_out      <= 1'b0;
                timeout_out    <= 1'b0;
            end
            if (state == READ && rd_done) dist_vertex_out <= vertex_pos_in;
            if (state == WAIT && dist_valid_in) begin
                if (last) found_out <= 1'b1;
                else      idx <= idx + 1'b1;
            end else if (state == WAIT && expired) begin
                timeout_out <= 1'b1;
            end
        end
    end

    min_tracker #(.IDX_W(ADDR_W)) u_min (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr       (accept),
        .upd       (state == WAIT && dist_valid_in),
        .cand_dist (dist_sq_in),
        .cand_idx  (idx),
        .best_dist (best_dist_sq_out),
        .best_idx  (best_idx_out)
    );
endmodule

// File: tb/tb_nn_search_ctrl.sv
// tb_nn_search_ctrl: directed bench with a BRAM model and a 40-cycle behavioural
// distance unit that can drop the result for one chosen vertex.
module tb_nn_search_ctrl;
    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              start_in = 1'b0;
    logic [1:0][31:0]  query_pos_in = '0;
    logic [6:0]        num_vertices_in = '0;
    logic [5:0]        vertex_addr_out;
    logic [1:0][31:0]  vertex_pos_in;
    logic [1:0]        dist_valid_out;
    logic [1:0][31:0]  dist_vertex_out;
    logic [1:0][31:0]  dist_query_out;
    logic [31:0]       dist_sq_in = '0;
    logic              dist_valid_in = 1'b0;
    logic              busy_out, done_out, found_out, timeout_out;
    logic [5:0]        best_idx_out;
    logic [31:0]       best_dist_sq_out;

    nn_search_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .query_pos_in(query_pos_in), .num_vertices_in(num_vertices_in),
        .vertex_addr_out(vertex_addr_out), .vertex_pos_in(vertex_pos_in),
        .dist_valid_out(dist_valid_out), .dist_vertex_out(dist_vertex_out),
        .dist_query_out(dist_query_out), .dist_sq_in(dist_sq_in),
        .dist_valid_in(dist_valid_in), .busy_out(busy_out), .done_out(done_out),
        .found_out(found_out), .timeout_out(timeout_out),
        .best_idx_out(best_idx_out), .best_dist_sq_out(best_dist_sq_out)
    );

    always #5 clk_in = ~clk_in;

    logic [1:0][31:0] mem [64];
    logic [1:0][31:0] p0 = '0, p1 = '0;
    always @(posedge clk_in) begin
        p0 <= mem[vertex_addr_out];
        p1 <= p0;
    end
    assign vertex_pos_in = p1;

    function automatic logic [31:0] dsq(input logic [1:0][31:0] v, input logic [1:0][31:0] q);
        logic [31:0] dx, dy;
        dx = v[0] > q[0] ? v[0] - q[0] : q[0] - v[0];
        dy = v[1] > q[1] ? v[1] - q[1] : q[1] - v[1];
        return dx * dx + dy * dy;
    endfunction

    int issues = 0, bad_bursts = 0, blen = 0, done_cnt = 0, cd = 0;
    logic prev_v = 1'b0, pend = 1'b0, sup_en = 1'b0;
    int sup_n = -1;
    logic [31:0] d_hold = '0;
    always @(posedge clk_in) begin
        prev_v <= dist_valid_out[0];
        dist_valid_in <= 1'b0;
        if (done_out) done_cnt <= done_cnt + 1;
        if (dist_valid_out != 2'b00 && dist_valid_out != 2'b11) bad_bursts <= bad_bursts + 1;
        if (dist_valid_out[0]) blen <= blen + 1;
        else begin
            if (blen != 0 && blen != 2) bad_bursts <= bad_bursts + 1;
            blen <= 0;
        end
        if (dist_valid_out[0] && !prev_v) begin
            issues <= issues + 1;
            d_hold <= dsq(dist_vertex_out, dist_query_out);
            pend   <= !(sup_en && issues == sup_n);
            cd     <= 40;
        end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1 && pend) begin
                dist_valid_in <= 1'b1;
                dist_sq_in    <= d_hold;
            end
        end
    end

    int tests = 0, fails = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_v(input int i, input logic [31:0] x, input logic [31:0] y);
        mem[i][0] = x;
        mem[i][1] = y;
    endtask

    task automatic start_search(input logic [31:0] qx, input logic [31:0] qy, input logic [6:0] n);
        @(negedge clk_in);
        query_pos_in[0] = qx;
        query_pos_in[1] = qy;
        num_vertices_in = n;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!done_out && cyc < 3000) begin
            @(negedge clk_in);
            cyc++;
        end
        check(tag, {31'd0, done_out}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic f, input logic t,
                                input logic [5:0] bi, input logic [31:0] bd);
        check({tag, "_found"}, {31'd0, found_out}, {31'd0, f});
        check({tag, "_timeout"}, {31'd0, timeout_out}, {31'd0, t});
        check({tag, "_idx"}, {26'd0, best_idx_out}, {26'd0, bi});
        check({tag, "_dist"}, best_dist_sq_out, bd);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
        check({tag, "_done"}, {31'd0, done_out}, 32'd0);
        check({tag, "_found"}, {31'd0, found_out}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout_out}, 32'd0);
        check({tag, "_idx"}, {26'd0, best_idx_out}, 32'd0);
        check({tag, "_dist"}, best_dist_sq_out, 32'hFFFF_FFFF);
        check({tag, "_addr"}, {26'd0, vertex_addr_out}, 32'd0);
        check({tag, "_dvalid"}, {30'd0, dist_valid_out}, 32'd0);
    endtask

    initial begin
        int cyc, base_i, base_d;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        set_v(0, 0, 0); set_v(1, 10, 10); set_v(2, 3, 4); set_v(3, 100, 0);
        repeat (3) @(negedge clk_in);
        check_reset_vals("reset");
        rst_in = 1'b0;

        base_i = issues; base_d = done_cnt;
        start_search(0, 0, 4);
        check("busy_after_start", {31'd0, busy_out}, 32'd1);
        wait_done("t1_done", cyc);
        check_result("t1", 1'b1, 1'b0, 6'd0, 32'd0);
        repeat (5) @(negedge clk_in);
        check("t1_done_once", done_cnt - base_d, 32'd1);
        check("t1_busy_clear", {31'd0, busy_out}, 32'd0);

        base_i = issues;
        start_search(4, 5, 4);
        wait_done("t2_done", cyc);
        check_result("t2", 1'b1, 1'b0, 6'd2, 32'd2);
        check("t2_issues", issues - base_i, 32'd4);

        set_v(0, 1, 0); set_v(1, 0, 1); set_v(2, 5, 5);
        start_search(0, 0, 3);
        wait_done("t3_done", cyc);
        check_result("t3", 1'b1, 1'b0, 6'd0, 32'd1);

        base_i = issues;
        start_search(0, 0, 0);
        wait_done("t4_done", cyc);
        check("t4_latency_ok", {31'd0, cyc <= 1}, 32'd1);
        check_result("t4", 1'b0, 1'b0, 6'd0, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk_in);
        check("t4_no_reads", issues - base_i, 32'd0);

        set_v(0, 0, 0); set_v(1, 10, 10); set_v(2, 3, 4); set_v(3, 100, 0);
        base_i = issues; base_d = done_cnt;
        sup_n = issues + 1; sup_en = 1'b1;
        start_search(4, 5, 4);
        repeat (3) @(negedge clk_in);
        start_in = 1'b1; num_vertices_in = 7'd0;
        @(negedge clk_in);
        start_in = 1'b0;
        wait_done("t5_done", cyc);
        check("t5_waited", {31'd0, cyc >= 255}, 32'd1);
        check_result("t5", 1'b0, 1'b1, 6'd0, 32'd41);
        repeat (10) @(negedge clk_in);
        sup_en = 1'b0;
        check("t5_done_once", done_cnt - base_d, 32'd1);
        check("t5_issues", issues - base_i, 32'd2);

        base_i = issues; base_d = done_cnt;
        start_search(0, 0, 4);
        cyc = 0;
        while (issues == base_i && cyc < 100) begin
            @(negedge clk_in);
            cyc++;
        end
        check("t6_issued", {31'd0, issues != base_i}, 32'd1);
        repeat (10) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        check_reset_vals("t6_rst");
        repeat (60) @(negedge clk_in);
        check("t6_no_done", done_cnt - base_d, 32'd0);
        check_reset_vals("t6_late");

        base_i = issues;
        start_search(4, 5, 4);
        wait_done("t7_done", cyc);
        check_result("t7", 1'b1, 1'b0, 6'd2, 32'd2);
        check("t7_issues", issues - base_i, 32'd4);
        check("burst_shape", bad_bursts, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
